hc153_tdm_demux: RTL and testbench
==================================

// Module: hc153_tdm_demux
// PURPOSE
//  Receive end of the 4:1 select path: de-multiplexes one time-shared data line back into 4 channel registers.
//  Samples arrive one slot per strobe, in round-robin order 0..3; a full 4-slot frame is presented in parallel.
//  Presentation uses a valid/ready handshake, with sticky overrun detection.
//  Sits after the HC153-style mux/serial link, feeding parallel consumers.
// PARAMETERS
//  WIDTH   1   bits per slot (DataIn width; DataOut is 4*WIDTH)
// PORTS
//  Clock       in   1        rising-edge clock, single domain
//  Reset       in   1        synchronous, active-high reset
//  DataIn      in   WIDTH    time-shared slot data
//  Strobe      in   1        DataIn valid this cycle
//  Enable      in   1        active-low enable; 1 = ignore Strobe/FrameSync, hold all state
//  FrameSync   in   1        force next capture to slot 0, discard partial frame
//  DataOut     out  4*WIDTH  frame; slot k at [k*WIDTH +: WIDTH]
//  FrameValid  out  1        DataOut holds an unconsumed frame
//  FrameReady  in   1        consumer accepts frame when FrameValid & FrameReady
//  SlotIdx     out  2        slot the next capture writes
//  Overrun     out  1        sticky: a completed frame was dropped
// BEHAVIOUR
//  - Reset (sync, at the edge with Reset=1): SlotIdx=0, hold regs=0, DataOut=0, FrameValid=0, Overrun=0.
//    Reset overrides all other inputs; a reset mid-frame discards the partial frame.
//  - Capture condition: cap = Strobe & ~Enable.
//  - Slot 0..2 capture: hold[SlotIdx] <= DataIn; SlotIdx increments at the same edge.
//  - Slot 3 capture completes the frame; SlotIdx wraps 3->0.
//  - FrameSync & ~Enable: SlotIdx forced to 0, partial hold contents discarded (not presented).
//    If cap is also high that cycle, DataIn is stored as slot 0 and SlotIdx becomes 1.
//  - Frame completion at edge E: DataOut <= {DataIn, hold[2], hold[1], hold[0]}; FrameValid=1 from E.
//    Latency: last slot to DataOut is 1 edge.
//  - Handshake: FrameValid stays high and DataOut stays stable until an edge with FrameValid & FrameReady;
//    FrameValid then clears.
//  - Completion at an edge where FrameValid=1 and FrameReady=1: the new frame loads and FrameValid stays 1.
//    Overrun is not set.
//  - Completion at an edge where FrameValid=1 and FrameReady=0: the new frame is dropped, DataOut unchanged,
//    Overrun <= 1. Overrun clears only on Reset.
//  - Enable=1: no capture and no sync. The handshake still operates (FrameReady may consume a frame).
//  - FrameReady while FrameValid=0 is ignored.
// CONFIGURATION
//  HC153_DEMUX_SEL_EN defined:
//  - Adds input Sel[1:0]; cap writes hold[Sel]. SlotIdx reports Sel.
//  - A 4-bit written-mask tracks written slots; the frame completes on the capture that makes the mask 4'b1111.
//  - The mask clears on completion, FrameSync or Reset. Rewriting a slot overwrites it without completing.
//  HC153_DEMUX_SEL_EN undefined:
//  - No Sel port; internal round-robin counter as above.
// TESTING
//  1 Reset: assert Reset 2 cycles with Strobe=1 -> DataOut=0, FrameValid=0, SlotIdx=0, Overrun=0.
//  2 WIDTH=1, FrameReady=1, Enable=0, strobes 1,0,1,1 -> DataOut=4'b1101, FrameValid high 1 cycle, SlotIdx=0.
//  3 Enable=1 during strobes 2-3 -> no capture, SlotIdx holds.
//    Resume with Enable=0 and 2 more strobes -> frame completes with those values.
//  4 After 2 strobes, FrameSync+Strobe(DataIn=1) -> SlotIdx=1; 3 more strobes 0,0,1 -> DataOut=4'b1001.
//  5 FrameReady=0: complete frame A, then frame B -> DataOut=A, Overrun=1.
//    FrameReady=1 then completes frame C -> DataOut=C, Overrun stays 1.
//  6 SEL_EN build: Sel=3,1,1,0,2 with data 1,0,1,0,1 -> completes on 5th strobe, DataOut=4'b1110.

Source files
------------

// File: rtl/hc153_tdm_demux_if.sv
// -----------------------------------------------------------------------------
// hc153_tdm_demux_if
// Bundles the slot input, frame output and handshake signals of the TDM demux.
//   master : upstream side, drives DataIn/Strobe/Enable/FrameSync/FrameReady
//            (and Sel when HC153_DEMUX_SEL_EN is defined)
//   slave  : the demux itself, drives DataOut/FrameValid/SlotIdx/Overrun
// Optional macro: HC153_DEMUX_SEL_EN adds the Sel[1:0] slot-select signal.
// -----------------------------------------------------------------------------
interface hc153_tdm_demux_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0]   DataIn;
   logic               Strobe;
   logic               Enable;
   logic               FrameSync;
   logic               FrameReady;
   logic [4*WIDTH-1:0] DataOut;
   logic               FrameValid;
   logic [1:0]         SlotIdx;
   logic               Overrun;
`ifdef HC153_DEMUX_SEL_EN
   logic [1:0]         Sel;
`endif

   modport master (
`ifdef HC153_DEMUX_SEL_EN
      output Sel,
`endif
      output DataIn, Strobe, Enable, FrameSync, FrameReady,
      input  DataOut, FrameValid, SlotIdx, Overrun
   );

   modport slave (
`ifdef HC153_DEMUX_SEL_EN
      input  Sel,
`endif
      input  DataIn, Strobe, Enable, FrameSync, FrameReady,
      output DataOut, FrameValid, SlotIdx, Overrun
   );
endinterface

// File: rtl/hc153_tdm_demux.sv
// -----------------------------------------------------------------------------
// hc153_tdm_demux
// Receive end of a 4:1 time-shared link: collects four WIDTH-bit slots into a
// frame and presents it in parallel through a valid/ready handshake.
// Ports:
//   Clock  : rising-edge clock
//   Reset  : synchronous, active-high; clears slot pointer, hold regs, frame,
//            FrameValid and Overrun
//   bus    : hc153_tdm_demux_if.slave
//            DataIn/Strobe   slot data and its strobe
//            Enable          active low; 1 freezes capture and sync
//            FrameSync       restart the frame at slot 0
//            DataOut         frame, slot k at [k*WIDTH +: WIDTH]
//            FrameValid/FrameReady  frame handshake
//            SlotIdx         slot written by the next capture
//            Overrun         sticky, a completed frame was dropped
// Optional macro: HC153_DEMUX_SEL_EN -- slot chosen by bus.Sel instead of the
//   internal round-robin pointer; a frame completes once all four slots have
//   been written since the last completion/sync/reset.
// -----------------------------------------------------------------------------
module hc153_tdm_demux #(
   parameter int WIDTH = 1
) (
   input logic              Clock,
   input logic              Reset,
   hc153_tdm_demux_if.slave bus
);

   typedef logic [3:0][WIDTH-1:0] frame_t;

   frame_t     hold_q, hold_d;
   frame_t     dout_q, dout_d;
   logic       valid_q, valid_d;
   logic       overrun_q, overrun_d;
   logic       cap, sync, complete;
`ifdef HC153_DEMUX_SEL_EN
   logic [3:0] mask_q, mask_d;
`else
   logic [1:0] slot_q, slot_d;
`endif

   // Handshake: a frame is transferred at a rising edge where FrameValid and
   // FrameReady are both high; until then DataOut is held stable. FrameReady
   // with FrameValid low has no effect. A frame completing while the previous
   // one is still pending is loaded only if that edge also consumes the old
   // frame, otherwise it is dropped and Overrun latches.
   always_comb begin
      cap       = bus.Strobe & ~bus.Enable;
      sync      = bus.FrameSync & ~bus.Enable;
      complete  = 1'b0;
      hold_d    = hold_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
`ifdef HC153_DEMUX_SEL_EN
      mask_d    = mask_q;
      if (sync) begin
         hold_d = '0;
         mask_d = '0;
         if (cap) begin
            hold_d[bus.Sel] = bus.DataIn;
            mask_d[bus.Sel] = 1'b1;
         end
      end else if (cap) begin
         hold_d[bus.Sel] = bus.DataIn;
         mask_d = mask_q | (4'b0001 << bus.Sel);
         if (mask_d == 4'b1111) begin
            complete = 1'b1;
            mask_d   = '0;
         end
      end
`else
      slot_d    = slot_q;
      if (sync) begin
         // Partial frame is discarded; a same-cycle strobe becomes slot 0.
         hold_d = '0;
         slot_d = 2'd0;
         if (cap) begin
            hold_d[0] = bus.DataIn;
            slot_d    = 2'd1;
         end
      end else if (cap) begin
         // Slot 3 is written into hold_d too so hold_d is the complete frame.
         hold_d[slot_q] = bus.DataIn;
         complete       = (slot_q == 2'd3);
         slot_d         = slot_q + 2'd1;
      end
`endif
      if (valid_q && bus.FrameReady) begin
         valid_d = 1'b0;
      end
      if (complete) begin
         if (!valid_q || bus.FrameReady) begin
            dout_d  = hold_d;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         hold_q    <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
`ifdef HC153_DEMUX_SEL_EN
         mask_q    <= '0;
`else
         slot_q    <= 2'd0;
`endif
      end else begin
         hold_q    <= hold_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
`ifdef HC153_DEMUX_SEL_EN
         mask_q    <= mask_d;
`else
         slot_q    <= slot_d;
`endif
      end
   end

   assign bus.DataOut    = dout_q;
   assign bus.FrameValid = valid_q;
   assign bus.Overrun    = overrun_q;
`ifdef HC153_DEMUX_SEL_EN
   assign bus.SlotIdx    = bus.Sel;
`else
   assign bus.SlotIdx    = slot_q;
`endif

endmodule

// File: tb/tb_hc153_tdm_demux.sv
module tb_hc153_tdm_demux;

   localparam int WIDTH = 1;
   localparam int W     = 4 * WIDTH;

   logic Clock;
   logic Reset;
   int   checks = 0;
   int   errors = 0;
   logic [W-1:0] exp_q[$];
`ifdef HC153_DEMUX_SEL_EN
   logic [1:0] sel_v;
`endif

   hc153_tdm_demux_if #(.WIDTH(WIDTH)) bus ();

   hc153_tdm_demux #(.WIDTH(WIDTH)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // clock / reset
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one cycle of stimulus; returns 1 time unit after the edge
   task automatic step(input logic s, input logic d, input logic fs);
      bus.Strobe    = s;
      bus.DataIn    = d;
      bus.FrameSync = fs;
`ifdef HC153_DEMUX_SEL_EN
      bus.Sel       = sel_v;
`endif
      @(posedge Clock);
      #1;
      bus.Strobe    = 1'b0;
      bus.FrameSync = 1'b0;
   endtask

   // scoreboard: every handshake transfer must match the oldest expected frame
   always @(negedge Clock) begin
      if (!Reset && bus.FrameValid === 1'b1 && bus.FrameReady === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_frame", bus.DataOut, 32'hFFFF_FFFF);
         end else begin
            chk("sb_frame", bus.DataOut, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      Reset          = 1'b1;
      bus.Strobe     = 1'b1;
      bus.DataIn     = 1'b1;
      bus.Enable     = 1'b0;
      bus.FrameSync  = 1'b0;
      bus.FrameReady = 1'b1;
`ifdef HC153_DEMUX_SEL_EN
      sel_v          = 2'd0;
      bus.Sel        = 2'd0;
`endif
      // 1: reset held two cycles with Strobe high
      @(posedge Clock);
      @(posedge Clock);
      #1;
      chk("rst_dataout", bus.DataOut, 0);
      chk("rst_valid", bus.FrameValid, 0);
      chk("rst_slotidx", bus.SlotIdx, 0);
      chk("rst_overrun", bus.Overrun, 0);
      Reset      = 1'b0;
      bus.Strobe = 1'b0;

`ifdef HC153_DEMUX_SEL_EN
      // 6: slot-select build, rewrite of slot 1 must not complete
      sel_v = 2'd3; step(1, 1, 0);
      chk("sel_slotidx", bus.SlotIdx, 3);
      sel_v = 2'd1; step(1, 0, 0);
      sel_v = 2'd1; step(1, 1, 0);
      chk("sel_rewrite_no_complete", bus.FrameValid, 0);
      sel_v = 2'd0; step(1, 0, 0);
      chk("sel_three_slots_no_complete", bus.FrameValid, 0);
      exp_q.push_back(4'b1110);
      sel_v = 2'd2; step(1, 1, 0);
      chk("sel_valid", bus.FrameValid, 1);
      chk("sel_dataout", bus.DataOut, 4'b1110);
      step(0, 0, 0);
      chk("sel_consumed", bus.FrameValid, 0);
      // next frame needs all four slots again
      sel_v = 2'd0; step(1, 1, 0);
      sel_v = 2'd1; step(1, 1, 0);
      sel_v = 2'd2; step(1, 1, 0);
      chk("sel_mask_cleared", bus.FrameValid, 0);
      exp_q.push_back(4'b0111);
      sel_v = 2'd3; step(1, 0, 0);
      chk("sel_second_frame", bus.DataOut, 4'b0111);
      step(0, 0, 0);
`else
      // 2: strobes 1,0,1,1
      step(1, 1, 0);
      chk("t2_slotidx_after1", bus.SlotIdx, 1);
      step(1, 0, 0);
      step(1, 1, 0);
      chk("t2_not_yet_valid", bus.FrameValid, 0);
      exp_q.push_back(4'b1101);
      step(1, 1, 0);
      chk("t2_valid", bus.FrameValid, 1);
      chk("t2_dataout", bus.DataOut, 4'b1101);
      chk("t2_slotidx_wrap", bus.SlotIdx, 0);
      step(0, 0, 0);
      chk("t2_valid_one_cycle", bus.FrameValid, 0);

      // 3: Enable high freezes capture and sync
      step(1, 0, 0);
      step(1, 1, 0);
      bus.Enable = 1'b1;
      step(1, 1, 0);
      step(1, 0, 1);
      chk("t3_slotidx_hold", bus.SlotIdx, 2);
      chk("t3_no_frame", bus.FrameValid, 0);
      bus.Enable = 1'b0;
      step(1, 1, 0);
      chk("t3_slotidx_resume", bus.SlotIdx, 3);
      exp_q.push_back(4'b0110);
      step(1, 0, 0);
      chk("t3_dataout", bus.DataOut, 4'b0110);
      step(0, 0, 0);

      // 4: FrameSync with a strobe restarts at slot 0
      step(1, 1, 0);
      step(1, 1, 0);
      step(1, 1, 1);
      chk("t4_sync_slotidx", bus.SlotIdx, 1);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("t4_no_early_frame", bus.FrameValid, 0);
      exp_q.push_back(4'b1001);
      step(1, 1, 0);
      chk("t4_dataout", bus.DataOut, 4'b1001);
      step(0, 0, 0);

      // reset mid-frame discards the partial frame
      step(1, 1, 0);
      step(1, 0, 0);
      Reset = 1'b1;
      step(1, 1, 0);
      Reset = 1'b0;
      chk("midrst_slotidx", bus.SlotIdx, 0);
      step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
      exp_q.push_back(4'b1111);
      step(1, 1, 0);
      chk("midrst_dataout", bus.DataOut, 4'b1111);
      step(0, 0, 0);

      // completion on the same edge that consumes the pending frame
      bus.FrameReady = 1'b0;
      exp_q.push_back(4'b0010);
      step(1, 0, 0); step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
      chk("bb_a_valid", bus.FrameValid, 1);
      step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
      chk("bb_a_held", bus.DataOut, 4'b0010);
      bus.FrameReady = 1'b1;
      exp_q.push_back(4'b1111);
      step(1, 1, 0);
      chk("bb_b_valid", bus.FrameValid, 1);
      chk("bb_b_dataout", bus.DataOut, 4'b1111);
      chk("bb_no_overrun", bus.Overrun, 0);
      step(0, 0, 0);
      chk("bb_consumed", bus.FrameValid, 0);

      // 5: overrun
      bus.FrameReady = 1'b0;
      exp_q.push_back(4'b0011);
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
      chk("t5_overrun_clear", bus.Overrun, 0);
      step(1, 0, 0); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
      chk("t5_dataout_kept", bus.DataOut, 4'b0011);
      chk("t5_overrun_set", bus.Overrun, 1);
      chk("t5_still_valid", bus.FrameValid, 1);
      bus.FrameReady = 1'b1;
      exp_q.push_back(4'b1000);
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
      chk("t5_c_dataout", bus.DataOut, 4'b1000);
      step(0, 0, 0);
      chk("t5_overrun_sticky", bus.Overrun, 1);
      chk("t5_c_consumed", bus.FrameValid, 0);
      chk("t5_dataout_stable", bus.DataOut, 4'b1000);
`endif

      // every expected frame must have been transferred
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge Clock);
      #1;
      chk("sb_drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
